button_gesture: RTL and testbench
=================================

// Module: button_gesture
// PURPOSE
//  Classifies a debounced, active-high button level into one-cycle gesture pulses:
//  short press, double press, long press, and auto-repeat while a long press is held.
//  Sits directly downstream of the debouncer: in_state connects to its out_state.
//  Outputs drive UI/menu logic that needs discrete events.
// PARAMETERS
//  LONG_CYCLES    50000  held cycles after the press before long_press fires (>=2)
//  GAP_CYCLES     20000  max cycles after a release for a second press to count as double (>=1)
//  REPEAT_CYCLES  10000  period of repeat pulses after long_press; 0 disables repeat
// PORTS
//  clk           in   1  single clock, all logic on posedge
//  rst           in   1  asynchronous, active-high reset
//  in_state      in   1  debounced button level, 1 = pressed
//  short_press   out  1  1-cycle pulse: single press-release, no second press within gap
//  double_press  out  1  1-cycle pulse: second press started within gap
//  long_press    out  1  1-cycle pulse: press held LONG_CYCLES
//  repeat_press  out  1  1-cycle pulse every REPEAT_CYCLES while held after long_press
//  busy          out  1  1 whenever state != IDLE (registered)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, all pulse outputs 0, busy=0, prev_state=1.
//  - prev_state <= in_state every cycle; IDLE reacts only to rise (in_state & ~prev_state),
//    so a button held through reset is ignored until released and pressed again.
//  - One counter, width $clog2(max(LONG_CYCLES,GAP_CYCLES,REPEAT_CYCLES)+1); cleared
//    on every state change, +1 per cycle while staying in PRESS1/GAP/LONG_HELD. Never wraps.
//  - Let edge k be the first clk edge sampling a rise in IDLE. All outputs registered:
//    a pulse decided at edge n is high for exactly the cycle after edge n.
//  - States/transitions (evaluated at each edge, in_state sampled):
//    IDLE:      rise -> PRESS1.
//    PRESS1:    in=0 -> GAP. else cnt==LONG_CYCLES-1 -> long_press, LONG_HELD.
//               (long_press decided at edge k+LONG_CYCLES.)
//    GAP:       in=1 -> double_press, WAIT_REL. else cnt==GAP_CYCLES-1 -> short_press, IDLE.
//               If release sampled at edge r, double window is edges r+1..r+GAP_CYCLES;
//               press at r+GAP_CYCLES (simultaneous with timeout) is a double, no short.
//    LONG_HELD: in=0 -> IDLE, no pulse. else if REPEAT_CYCLES!=0 and cnt==REPEAT_CYCLES-1
//               -> repeat_press, cnt=0, stay. First repeat at edge k+LONG+REPEAT.
//    WAIT_REL:  in=0 -> IDLE. No pulses; long hold after double gives nothing further.
//  - At most one pulse output high in any cycle. Release in LONG_HELD never yields short.
//  - Glitch-free in_state assumed (debounced); a 1-cycle press still counts as a press.
//  - Reset asserted mid-gesture: immediate return to IDLE, pending pulse dropped, no
//    pulse emitted on deassertion.
//  - Unused/illegal state encodings return to IDLE next cycle.
// TESTING (LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3)
//  - Press 3 cycles, release at edge r, stay low -> short_press single pulse after r+4; no others.
//  - Press 3, release at r, press again at r+2 -> double_press after r+2; release -> busy=0, no short.
//  - Press at r+4 exactly (window edge) -> double_press, no short_press.
//  - Hold from edge k for 20 cycles -> long_press after k+8, repeat_press after k+11,k+14,k+17;
//    release -> IDLE, no short. With REPEAT_CYCLES=0 -> only long_press.
//  - Hold in_state=1 across rst release -> no pulses, busy=0; release, press 3 -> short.
//  - Assert rst in PRESS1 at cnt=5 and in GAP -> outputs 0, busy=0, no pulse after release.

Source files
------------

// File: rtl/button_gesture.sv
// button_gesture: turns a debounced button level into one-cycle gesture pulses.
// Ports:
//   clk, rst (async, active high), in_state (1 = pressed)
//   short_press, double_press, long_press, repeat_press: 1-cycle pulses
//   busy: high whenever the classifier is not idle
module button_gesture #(
   parameter int LONG_CYCLES   = 50000,
   parameter int GAP_CYCLES    = 20000,
   parameter int REPEAT_CYCLES = 10000
) (
   input  logic clk,
   input  logic rst,
   input  logic in_state,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic busy
);

   localparam int MAX_LG = (LONG_CYCLES > GAP_CYCLES) ?
                           LONG_CYCLES : GAP_CYCLES;
   localparam int MAX_C  = (MAX_LG > REPEAT_CYCLES) ?
                           MAX_LG : REPEAT_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   // Repeat disabled when REPEAT_CYCLES == 0; keep the constant legal anyway.
   localparam logic [CW-1:0] REP_LAST  =
      CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRESS1    = 3'd1,
      S_GAP       = 3'd2,
      S_LONG_HELD = 3'd3,
      S_WAIT_REL  = 3'd4
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_prev;
   logic          r_short;
   logic          r_double;
   logic          r_long;
   logic          r_repeat;
   logic          r_busy;

   logic          w_rise;
   logic [CW-1:0] w_cnt_inc;

   assign w_rise    = in_state & ~r_prev;
   // Saturate so a long hold with repeat disabled never wraps.
   assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_prev   <= 1'b1;
         r_short  <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_repeat <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_prev   <= in_state;
         r_short  <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_repeat <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_PRESS1;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_PRESS1: begin
               if (!in_state) begin
                  r_state <= S_GAP;
                  r_cnt   <= '0;
               end else if (r_cnt == LONG_LAST) begin
                  r_long  <= 1'b1;
                  r_state <= S_LONG_HELD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= w_cnt_inc;
               end
            end
            S_GAP: begin
               // A press on the timeout edge still wins as a double.
               if (in_state) begin
                  r_double <= 1'b1;
                  r_state  <= S_WAIT_REL;
                  r_cnt    <= '0;
               end else if (r_cnt == GAP_LAST) begin
                  r_short  <= 1'b1;
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_busy   <= 1'b0;
               end else begin
                  r_cnt    <= w_cnt_inc;
               end
            end
            S_LONG_HELD: begin
               if (!in_state) begin
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_busy   <= 1'b0;
               end else if (REPEAT_CYCLES != 0 && r_cnt == REP_LAST) begin
                  r_repeat <= 1'b1;
                  r_cnt    <= '0;
               end else begin
                  r_cnt    <= w_cnt_inc;
               end
            end
            S_WAIT_REL: begin
               if (!in_state) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign short_press  = r_short;
   assign double_press = r_double;
   assign long_press   = r_long;
   assign repeat_press = r_repeat;
   assign busy         = r_busy;

endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed checks of button_gesture gestures.
// Edge numbers are counted per step; pulses are logged after each edge.
module tb_button_gesture;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_state = 1'b0;
   logic short_press, double_press, long_press, repeat_press, busy;
   logic s0, d0, l0, r0, b0;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;
   int n_short, n_double, n_long, n_rep, n_multi;
   int n_long0, n_rep0, n_other0;
   int t_short, t_double, t_long, t_long0;
   int rep_t [0:3];
   int k, r;

   always #5 clk = ~clk;

   button_gesture #(
      .LONG_CYCLES(8), .GAP_CYCLES(4), .REPEAT_CYCLES(3)
   ) dut (
      .clk(clk), .rst(rst), .in_state(in_state),
      .short_press(short_press), .double_press(double_press),
      .long_press(long_press), .repeat_press(repeat_press),
      .busy(busy)
   );

   button_gesture #(
      .LONG_CYCLES(8), .GAP_CYCLES(4), .REPEAT_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .in_state(in_state),
      .short_press(s0), .double_press(d0),
      .long_press(l0), .repeat_press(r0),
      .busy(b0)
   );

   task automatic clr();
      n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
      n_multi = 0; n_long0 = 0; n_rep0 = 0; n_other0 = 0;
      t_short = -1; t_double = -1; t_long = -1; t_long0 = -1;
      for (int i = 0; i < 4; i++) rep_t[i] = -1;
   endtask

   // Drive in_state, let one edge sample it, then log what that edge decided.
   task automatic step(input logic v);
      int hot;
      in_state = v;
      @(posedge clk);
      #1;
      edge_no++;
      hot = int'(short_press) + int'(double_press) +
            int'(long_press) + int'(repeat_press);
      if (hot > 1) n_multi++;
      if (short_press) begin n_short++; t_short = edge_no; end
      if (double_press) begin n_double++; t_double = edge_no; end
      if (long_press) begin n_long++; t_long = edge_no; end
      if (repeat_press) begin
         if (n_rep < 4) rep_t[n_rep] = edge_no;
         n_rep++;
      end
      if (l0) begin n_long0++; t_long0 = edge_no; end
      if (r0) n_rep0++;
      if (s0 || d0) n_other0++;
   endtask

   task automatic press_release3();
      step(1'b1); k = edge_no;
      step(1'b1); step(1'b1);
      step(1'b0); r = edge_no;
   endtask

   task automatic test_reset();
      clr();
      rst = 1'b1;
      step(1'b0); step(1'b0);
      checks++;
      if ({short_press, double_press, long_press, repeat_press} !== 4'b0) begin
         failures++;
         $display("FAIL reset_pulses got=%b exp=0000",
                  {short_press, double_press, long_press, repeat_press});
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b exp=0", busy);
      end
      rst = 1'b0;
      step(1'b0); step(1'b0);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL post_reset_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_short();
      clr();
      step(1'b1); k = edge_no;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL press_busy got=%b exp=1", busy);
      end
      step(1'b1); step(1'b1);
      step(1'b0); r = edge_no;
      for (int i = 0; i < 8; i++) step(1'b0);
      checks++;
      if (n_short !== 1) begin
         failures++; $display("FAIL short_count got=%0d exp=1", n_short);
      end
      checks++;
      if (t_short !== r + 4) begin
         failures++; $display("FAIL short_time got=%0d exp=%0d", t_short, r + 4);
      end
      checks++;
      if (n_double + n_long + n_rep !== 0) begin
         failures++;
         $display("FAIL short_others got=%0d exp=0", n_double + n_long + n_rep);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL short_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_double();
      clr();
      press_release3();
      step(1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      for (int i = 0; i < 6; i++) step(1'b0);
      checks++;
      if (n_double !== 1 || t_double !== r + 2) begin
         failures++;
         $display("FAIL double_time got=%0d/%0d exp=1/%0d", n_double, t_double, r + 2);
      end
      checks++;
      if (n_short !== 0) begin
         failures++; $display("FAIL double_short got=%0d exp=0", n_short);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL double_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_window_edge();
      clr();
      press_release3();
      step(1'b0); step(1'b0); step(1'b0);
      step(1'b1);
      step(1'b0);
      for (int i = 0; i < 6; i++) step(1'b0);
      checks++;
      if (n_double !== 1 || t_double !== r + 4) begin
         failures++;
         $display("FAIL window_double got=%0d/%0d exp=1/%0d", n_double, t_double, r + 4);
      end
      checks++;
      if (n_short !== 0) begin
         failures++; $display("FAIL window_short got=%0d exp=0", n_short);
      end
   endtask

   // Second press one edge past the window: a short, then a fresh 1-cycle press.
   task automatic test_back_to_back();
      clr();
      press_release3();
      for (int i = 0; i < 4; i++) step(1'b0);
      step(1'b1);
      step(1'b0);
      for (int i = 0; i < 8; i++) step(1'b0);
      checks++;
      if (n_short !== 2 || t_short !== r + 10) begin
         failures++;
         $display("FAIL b2b_short got=%0d/%0d exp=2/%0d", n_short, t_short, r + 10);
      end
      checks++;
      if (n_double !== 0) begin
         failures++; $display("FAIL b2b_double got=%0d exp=0", n_double);
      end
   endtask

   task automatic test_long();
      clr();
      step(1'b1); k = edge_no;
      for (int i = 0; i < 19; i++) step(1'b1);
      step(1'b0);
      for (int i = 0; i < 6; i++) step(1'b0);
      checks++;
      if (n_long !== 1 || t_long !== k + 8) begin
         failures++;
         $display("FAIL long_time got=%0d/%0d exp=1/%0d", n_long, t_long, k + 8);
      end
      checks++;
      if (n_rep !== 3) begin
         failures++; $display("FAIL repeat_count got=%0d exp=3", n_rep);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rep_t[i] !== k + 11 + 3 * i) begin
            failures++;
            $display("FAIL repeat_time%0d got=%0d exp=%0d", i, rep_t[i], k + 11 + 3 * i);
         end
      end
      checks++;
      if (n_short + n_double !== 0) begin
         failures++; $display("FAIL long_others got=%0d exp=0", n_short + n_double);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL long_busy got=%b exp=0", busy);
      end
      checks++;
      if (n_long0 !== 1 || t_long0 !== k + 8) begin
         failures++;
         $display("FAIL norep_long got=%0d/%0d exp=1/%0d", n_long0, t_long0, k + 8);
      end
      checks++;
      if (n_rep0 + n_other0 !== 0 || b0 !== 1'b0) begin
         failures++;
         $display("FAIL norep_others got=%0d busy=%b exp=0/0", n_rep0 + n_other0, b0);
      end
   endtask

   task automatic test_hold_reset();
      clr();
      rst = 1'b1;
      step(1'b1); step(1'b1);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) step(1'b1);
      checks++;
      if (busy !== 1'b0 || n_short + n_double + n_long + n_rep !== 0) begin
         failures++;
         $display("FAIL hold_rst got busy=%b pulses=%0d exp=0/0",
                  busy, n_short + n_double + n_long + n_rep);
      end
      step(1'b0);
      press_release3();
      for (int i = 0; i < 6; i++) step(1'b0);
      checks++;
      if (n_short !== 1 || t_short !== r + 4) begin
         failures++;
         $display("FAIL hold_short got=%0d/%0d exp=1/%0d", n_short, t_short, r + 4);
      end
   endtask

   task automatic test_rst_mid();
      clr();
      step(1'b1);
      for (int i = 0; i < 5; i++) step(1'b1);
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || long_press !== 1'b0) begin
         failures++;
         $display("FAIL rst_press1 got busy=%b long=%b exp=0/0", busy, long_press);
      end
      step(1'b1);
      rst = 1'b0;
      step(1'b1); step(1'b1);
      for (int i = 0; i < 10; i++) step(1'b0);
      checks++;
      if (n_short + n_double + n_long + n_rep !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_press1_after got pulses=%0d busy=%b exp=0/0",
                  n_short + n_double + n_long + n_rep, busy);
      end
      clr();
      press_release3();
      step(1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || short_press !== 1'b0) begin
         failures++;
         $display("FAIL rst_gap got busy=%b short=%b exp=0/0", busy, short_press);
      end
      step(1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0);
      checks++;
      if (n_short + n_double + n_long + n_rep !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_gap_after got pulses=%0d busy=%b exp=0/0",
                  n_short + n_double + n_long + n_rep, busy);
      end
   endtask

   int multi_total = 0;

   initial begin
      test_reset();
      test_short();
      multi_total += n_multi;
      test_double();
      multi_total += n_multi;
      test_window_edge();
      multi_total += n_multi;
      test_back_to_back();
      multi_total += n_multi;
      test_long();
      multi_total += n_multi;
      test_hold_reset();
      multi_total += n_multi;
      test_rst_mid();
      checks++;
      if (multi_total !== 0) begin
         failures++; $display("FAIL onehot got=%0d exp=0", multi_total);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
